// File: rtl/i2c_target_regfile_if.sv
// rtl/i2c_target_regfile_if.sv - pad and host-port bundle for the I2C target register file
//
// Purpose: groups the open-drain pad signals and the host register port of
// i2c_target_regfile into one interface.
// Ports:
//   scl_i, sda_i   pad inputs (asynchronous to clk)
//   sda_oe         1 = target pulls SDA low
//   hw_we/hw_addr/hw_wdata/hw_rdata  host register access
//   wr_stb/wr_idx/wr_data            per-byte notification of I2C writes
//   busy           target is addressed
// Modports: slave = the target, master = the surrounding logic / pad model.
interface i2c_target_regfile_if #(
  parameter int NREGS = 16
);
  localparam int IDXW = (NREGS > 1) ? $clog2(NREGS) : 1;

  logic            scl_i;
  logic            sda_i;
  logic            sda_oe;
  logic            hw_we;
  logic [IDXW-1:0] hw_addr;
  logic [7:0]      hw_wdata;
  logic [7:0]      hw_rdata;
  logic            wr_stb;
  logic [IDXW-1:0] wr_idx;
  logic [7:0]      wr_data;
  logic            busy;

  modport slave (
    input  scl_i, sda_i, hw_we, hw_addr, hw_wdata,
    output sda_oe, hw_rdata, wr_stb, wr_idx, wr_data, busy
  );

  modport master (
    output scl_i, sda_i, hw_we, hw_addr, hw_wdata,
    input  sda_oe, hw_rdata, wr_stb, wr_idx, wr_data, busy
  );
endinterface

// File: rtl/i2c_target_regfile.sv
// rtl/i2c_target_regfile.sv - I2C target with a pointer-addressed byte register bank
//
// Purpose: decodes START/STOP on synchronized SCL/SDA, matches a 7-bit
// address, serves pointer writes, data writes and auto-incrementing reads
// from an NREGS x 8 register bank, and exposes a host port for preload and
// write observation.
// Ports:
//   clk   system clock, rising edge
//   rst   synchronous active-low reset
//   bus   i2c_target_regfile_if.slave (pads, host port, write strobe, busy)
module i2c_target_regfile #(
  parameter logic [6:0] DEV_ADDR = 7'h55,
  parameter int         NREGS    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  i2c_target_regfile_if.slave   bus
);
  localparam int IDXW = (NREGS > 1) ? $clog2(NREGS) : 1;
  localparam logic [IDXW-1:0] PTR_ONE = 1;

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK
  } state_t;

  state_t          state_q, state_d;
  logic [2:0]      scl_sync_q, scl_sync_d;
  logic [2:0]      sda_sync_q, sda_sync_d;
  logic [3:0]      bit_cnt_q, bit_cnt_d;
  logic [7:0]      shift_q, shift_d;
  logic [7:0]      tx_q, tx_d;
  logic [IDXW-1:0] ptr_q, ptr_d;
  logic            rw_q, rw_d;
  logic            ack_clk_q, ack_clk_d;
  logic            sda_oe_q, sda_oe_d;
  logic            busy_q, busy_d;
  logic            wr_stb_q, wr_stb_d;
  logic [IDXW-1:0] wr_idx_q, wr_idx_d;
  logic [7:0]      wr_data_q, wr_data_d;
  logic [7:0]      regs_q [NREGS];
  logic [7:0]      regs_d [NREGS];

  // [0],[1] are the two synchronizer stages, [2] is the edge-detect history.
  logic scl, scl_prev, sda, sda_prev;
  logic scl_rise, scl_fall, start_det, stop_det;
  logic [7:0] rx_byte;

  assign scl       = scl_sync_q[1];
  assign scl_prev  = scl_sync_q[2];
  assign sda       = sda_sync_q[1];
  assign sda_prev  = sda_sync_q[2];
  assign scl_rise  = scl & ~scl_prev;
  assign scl_fall  = ~scl & scl_prev;
  assign start_det = scl & scl_prev & sda_prev & ~sda;
  assign stop_det  = scl & scl_prev & ~sda_prev & sda;
  assign rx_byte   = {shift_q[6:0], sda};

  always_comb begin
    state_d    = state_q;
    scl_sync_d = {scl_sync_q[1:0], bus.scl_i};
    sda_sync_d = {sda_sync_q[1:0], bus.sda_i};
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    tx_d       = tx_q;
    ptr_d      = ptr_q;
    rw_d       = rw_q;
    ack_clk_d  = ack_clk_q;
    sda_oe_d   = sda_oe_q;
    busy_d     = busy_q;
    wr_stb_d   = 1'b0;
    wr_idx_d   = wr_idx_q;
    wr_data_d  = wr_data_q;
    regs_d     = regs_q;

    // Host write first so a same-cycle I2C write to the same index overrides it.
    if (bus.hw_we) regs_d[bus.hw_addr] = bus.hw_wdata;

    if (stop_det) begin
      state_d  = IDLE;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
    end else if (start_det) begin
      // Also covers repeated START; the pointer is deliberately kept.
      state_d   = ADDR;
      bit_cnt_d = 4'd0;
      sda_oe_d  = 1'b0;
      ack_clk_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: ;

        ADDR, PTR, WDATA: begin
          if (scl_rise) begin
            shift_d   = rx_byte;
            bit_cnt_d = bit_cnt_q + 4'd1;
            ack_clk_d = 1'b0;
            if (bit_cnt_q == 4'd7) begin
              bit_cnt_d = 4'd0;
              if (state_q == ADDR) begin
                if (rx_byte[7:1] == DEV_ADDR) begin
                  state_d = ADDR_ACK;
                  rw_d    = rx_byte[0];
                  busy_d  = 1'b1;
                end else begin
                  state_d = IDLE;
                  busy_d  = 1'b0;
                end
              end else if (state_q == PTR) begin
                ptr_d   = rx_byte[IDXW-1:0];
                state_d = PTR_ACK;
              end else begin
                regs_d[ptr_q] = rx_byte;
                wr_stb_d      = 1'b1;
                wr_idx_d      = ptr_q;
                wr_data_d     = rx_byte;
                ptr_d         = ptr_q + PTR_ONE;
                state_d       = WDATA_ACK;
              end
            end
          end
        end

        // First SCL fall after bit 8 pulls SDA; the rise of the 9th clock is
        // remembered so the following fall releases it and moves on.
        ADDR_ACK, PTR_ACK, WDATA_ACK: begin
          if (scl_fall) begin
            if (!ack_clk_q) begin
              sda_oe_d = 1'b1;
            end else begin
              sda_oe_d  = 1'b0;
              ack_clk_d = 1'b0;
              bit_cnt_d = 4'd0;
              if (state_q == ADDR_ACK && rw_q) begin
                // Read: the releasing fall is also where the first data bit goes out.
                state_d  = RDATA;
                tx_d     = regs_q[ptr_q];
                sda_oe_d = ~regs_q[ptr_q][7];
              end else if (state_q == ADDR_ACK) begin
                state_d = PTR;
              end else begin
                state_d = WDATA;
              end
            end
          end else if (scl_rise && sda_oe_q) begin
            ack_clk_d = 1'b1;
          end
        end

        // bit_cnt counts SCL rises of the byte; a fall with bit_cnt==0 only
        // happens after a master ACK and loads the next byte.
        RDATA: begin
          if (scl_rise) begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (scl_fall) begin
            if (bit_cnt_q == 4'd8) begin
              sda_oe_d = 1'b0;
              state_d  = RDATA_ACK;
            end else if (bit_cnt_q == 4'd0) begin
              tx_d     = regs_q[ptr_q];
              sda_oe_d = ~regs_q[ptr_q][7];
            end else begin
              sda_oe_d = ~tx_q[3'd7 - bit_cnt_q[2:0]];
            end
          end
        end

        RDATA_ACK: begin
          if (scl_rise) begin
            if (!sda) begin
              ptr_d     = ptr_q + PTR_ONE;
              bit_cnt_d = 4'd0;
              state_d   = RDATA;
            end else begin
              state_d = IDLE;
              busy_d  = 1'b0;
            end
          end
        end

        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      scl_sync_q <= 3'b111;
      sda_sync_q <= 3'b111;
      bit_cnt_q  <= 4'd0;
      shift_q    <= 8'h00;
      tx_q       <= 8'h00;
      ptr_q      <= '0;
      rw_q       <= 1'b0;
      ack_clk_q  <= 1'b0;
      sda_oe_q   <= 1'b0;
      busy_q     <= 1'b0;
      wr_stb_q   <= 1'b0;
      wr_idx_q   <= '0;
      wr_data_q  <= 8'h00;
      for (int i = 0; i < NREGS; i++) regs_q[i] <= 8'h00;
    end else begin
      state_q    <= state_d;
      scl_sync_q <= scl_sync_d;
      sda_sync_q <= sda_sync_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
      ptr_q      <= ptr_d;
      rw_q       <= rw_d;
      ack_clk_q  <= ack_clk_d;
      sda_oe_q   <= sda_oe_d;
      busy_q     <= busy_d;
      wr_stb_q   <= wr_stb_d;
      wr_idx_q   <= wr_idx_d;
      wr_data_q  <= wr_data_d;
      regs_q     <= regs_d;
    end
  end

  assign bus.sda_oe   = sda_oe_q;
  assign bus.busy     = busy_q;
  assign bus.wr_stb   = wr_stb_q;
  assign bus.wr_idx   = wr_idx_q;
  assign bus.wr_data  = wr_data_q;
  assign bus.hw_rdata = regs_q[bus.hw_addr];
endmodule

// File: tb/tb_i2c_target_regfile.sv
// tb/tb_i2c_target_regfile.sv - directed bench for i2c_target_regfile with write/read scoreboards
module tb_i2c_target_regfile;
  logic clk;
  logic rst;
  logic m_scl;
  logic m_sda;
  int   n_cmp;
  int   n_fail;
  int   stb_cnt;
  int   oe_cnt;
  logic [11:0] exp_wr_q [$];
  logic [7:0]  exp_rd_q [$];

  i2c_target_regfile_if #(.NREGS(16)) bus ();

  i2c_target_regfile #(.DEV_ADDR(7'h55), .NREGS(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // Open-drain line: master releases high or pulls low, target can only pull low.
  assign bus.scl_i = m_scl;
  assign bus.sda_i = m_sda & ~bus.sda_oe;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst === 1'b1) begin
      if (bus.sda_oe === 1'b1) oe_cnt++;
      if (bus.wr_stb === 1'b1) begin
        logic [11:0] e;
        stb_cnt++;
        check("wr_stb_expected", 32'(exp_wr_q.size() != 0), 32'd1);
        if (exp_wr_q.size() != 0) begin
          e = exp_wr_q.pop_front();
          check("wr_idx", 32'(bus.wr_idx), 32'(e[11:8]));
          check("wr_data", 32'(bus.wr_data), 32'(e[7:0]));
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clock_bit(input logic b, output logic s);
    m_sda = b; cyc(4);
    m_scl = 1'b1; cyc(4);
    s = bus.sda_i; cyc(4);
    m_scl = 1'b0; cyc(4);
  endtask

  task automatic i2c_start();
    m_sda = 1'b1; cyc(4);
    m_scl = 1'b1; cyc(8);
    m_sda = 1'b0; cyc(8);
    m_scl = 1'b0; cyc(4);
  endtask

  task automatic i2c_stop();
    m_sda = 1'b0; cyc(4);
    m_scl = 1'b1; cyc(8);
    m_sda = 1'b1; cyc(8);
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) clock_bit(b[i], s);
    clock_bit(1'b1, s);
    ack = ~s;
  endtask

  // Last data bit raises hw_we to reg[5] for exactly the cycle whose edge
  // performs the I2C write (SCL rise + 3 clk).
  task automatic write_byte_collide(input logic [7:0] b, input logic [7:0] hdata, output logic ack);
    logic s;
    for (int i = 7; i >= 1; i--) clock_bit(b[i], s);
    m_sda = b[0]; cyc(4);
    m_scl = 1'b1; cyc(2);
    bus.hw_addr = 4'd5; bus.hw_wdata = hdata; bus.hw_we = 1'b1; cyc(1);
    bus.hw_we = 1'b0; cyc(5);
    m_scl = 1'b0; cyc(4);
    clock_bit(1'b1, s);
    ack = ~s;
  endtask

  task automatic read_byte(input logic master_ack, output logic [7:0] d);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      clock_bit(1'b1, s);
      d[i] = s;
    end
    clock_bit(~master_ack, s);
  endtask

  task automatic host_write(input logic [3:0] a, input logic [7:0] d);
    bus.hw_addr = a; bus.hw_wdata = d; bus.hw_we = 1'b1; cyc(1);
    bus.hw_we = 1'b0;
  endtask

  task automatic check_reg(input string tag, input logic [3:0] a, input logic [7:0] exp);
    bus.hw_addr = a; #1;
    check(tag, 32'(bus.hw_rdata), 32'(exp));
  endtask

  initial begin
    logic       ack;
    logic [7:0] d;
    int         stb_snap;
    int         oe_snap;
    n_cmp = 0; n_fail = 0; stb_cnt = 0; oe_cnt = 0;
    m_scl = 1'b1; m_sda = 1'b1; rst = 1'b0;
    bus.hw_we = 1'b0; bus.hw_addr = '0; bus.hw_wdata = '0;
    cyc(3);
    rst = 1'b1;
    #1;
    check("rst_sda_oe", 32'(bus.sda_oe), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_wr_stb", 32'(bus.wr_stb), 32'd0);
    check("rst_wr_idx", 32'(bus.wr_idx), 32'd0);
    check("rst_wr_data", 32'(bus.wr_data), 32'd0);
    check_reg("rst_reg9", 4'd9, 8'h00);
    cyc(2);

    // Reset while the target pulls SDA for bit 7 of reg[0] (=0x00).
    host_write(4'd7, 8'h5A);
    check_reg("preload_reg7", 4'd7, 8'h5A);
    i2c_start();
    write_byte(8'hAA, ack); check("t1_addr_ack", 32'(ack), 32'd1);
    write_byte(8'h00, ack); check("t1_ptr_ack", 32'(ack), 32'd1);
    i2c_start();
    write_byte(8'hAB, ack); check("t1_raddr_ack", 32'(ack), 32'd1);
    cyc(1);
    check("t1_read_drive", 32'(bus.sda_oe), 32'd1);
    rst = 1'b0; cyc(1);
    check("t1_rst_sda_oe", 32'(bus.sda_oe), 32'd0);
    check("t1_rst_busy", 32'(bus.busy), 32'd0);
    check_reg("t1_rst_reg7", 4'd7, 8'h00);
    rst = 1'b1;
    m_scl = 1'b1; cyc(4);
    m_sda = 1'b1; cyc(8);

    // Pointer write then two data bytes.
    exp_wr_q.push_back({4'd3, 8'h5C});
    exp_wr_q.push_back({4'd4, 8'hA7});
    i2c_start();
    write_byte(8'hAA, ack); check("t2_addr_ack", 32'(ack), 32'd1);
    check("t2_busy", 32'(bus.busy), 32'd1);
    write_byte(8'h03, ack); check("t2_ptr_ack", 32'(ack), 32'd1);
    write_byte(8'h5C, ack); check("t2_d0_ack", 32'(ack), 32'd1);
    write_byte(8'hA7, ack); check("t2_d1_ack", 32'(ack), 32'd1);
    i2c_stop();
    check("t2_busy_after_stop", 32'(bus.busy), 32'd0);
    check_reg("t2_reg3", 4'd3, 8'h5C);
    check_reg("t2_reg4", 4'd4, 8'hA7);
    check("t2_stb_count", 32'(stb_cnt), 32'd2);

    // Write pointer, repeated START, read with wrap.
    host_write(4'd15, 8'h11);
    host_write(4'd0, 8'h22);
    exp_rd_q.push_back(8'h11);
    exp_rd_q.push_back(8'h22);
    i2c_start();
    write_byte(8'hAA, ack); check("t3_addr_ack", 32'(ack), 32'd1);
    write_byte(8'h0F, ack); check("t3_ptr_ack", 32'(ack), 32'd1);
    i2c_start();
    write_byte(8'hAB, ack); check("t3_raddr_ack", 32'(ack), 32'd1);
    read_byte(1'b1, d); check("t3_rd0", 32'(d), 32'(exp_rd_q.pop_front()));
    read_byte(1'b0, d); check("t3_rd1", 32'(d), 32'(exp_rd_q.pop_front()));
    check("t3_busy_after_nack", 32'(bus.busy), 32'd0);
    check("t3_sda_released", 32'(bus.sda_oe), 32'd0);
    i2c_stop();

    // Address mismatch: target must stay silent.
    stb_snap = stb_cnt; oe_snap = oe_cnt;
    i2c_start();
    write_byte(8'hA8, ack); check("t4_addr_nack", 32'(ack), 32'd0);
    check("t4_busy", 32'(bus.busy), 32'd0);
    write_byte(8'h12, ack); check("t4_d0_nack", 32'(ack), 32'd0);
    write_byte(8'h34, ack); check("t4_d1_nack", 32'(ack), 32'd0);
    check("t4_no_oe", 32'(oe_cnt - oe_snap), 32'd0);
    check("t4_no_stb", 32'(stb_cnt - stb_snap), 32'd0);
    i2c_stop();

    // STOP after 4 bits of a data byte.
    stb_snap = stb_cnt;
    i2c_start();
    write_byte(8'hAA, ack); check("t5_addr_ack", 32'(ack), 32'd1);
    write_byte(8'h06, ack); check("t5_ptr_ack", 32'(ack), 32'd1);
    for (int i = 0; i < 4; i++) clock_bit(1'b1, ack);
    i2c_stop();
    check("t5_busy", 32'(bus.busy), 32'd0);
    check("t5_no_stb", 32'(stb_cnt - stb_snap), 32'd0);
    check_reg("t5_reg6_untouched", 4'd6, 8'h00);
    exp_wr_q.push_back({4'd6, 8'h3C});
    i2c_start();
    write_byte(8'hAA, ack); check("t5_retry_ack", 32'(ack), 32'd1);
    write_byte(8'h06, ack); check("t5_retry_ptr_ack", 32'(ack), 32'd1);
    write_byte(8'h3C, ack); check("t5_retry_d_ack", 32'(ack), 32'd1);
    i2c_stop();
    check_reg("t5_reg6", 4'd6, 8'h3C);

    // Same-cycle host and I2C write to reg[5]: I2C value must survive.
    exp_wr_q.push_back({4'd5, 8'h02});
    i2c_start();
    write_byte(8'hAA, ack); check("t6_addr_ack", 32'(ack), 32'd1);
    write_byte(8'h05, ack); check("t6_ptr_ack", 32'(ack), 32'd1);
    write_byte_collide(8'h02, 8'h01, ack); check("t6_d_ack", 32'(ack), 32'd1);
    i2c_stop();
    check_reg("t6_reg5", 4'd5, 8'h02);

    cyc(4);
    check("wr_queue_drained", 32'(exp_wr_q.size()), 32'd0);
    check("rd_queue_drained", 32'(exp_rd_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
